// File: rtl/ls_mem_sequencer.sv
// rtl/ls_mem_sequencer.sv - in-order LS request FIFO feeding a byte-wide req/ack memory port
// Loads return {8'b0, rdata} with their Rd tag on a valid/ready result port; stores complete silently.
module ls_mem_sequencer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 25,
  parameter int DATA_W = 8,
  parameter int TAG_W  = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_data,
  input  logic                       req_R_nW,
  input  logic [TAG_W-1:0]           req_tag,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       mem_R_nW,
  input  logic                       mem_ack,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [15:0]                res_data,
  output logic [TAG_W-1:0]           res_tag,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              rnw_mem  [DEPTH];
  logic [TAG_W-1:0]  tag_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;

  logic              mem_req_d, mem_R_nW_d, res_valid_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [15:0]       res_data_d;
  logic [TAG_W-1:0]  res_tag_d;

  assign req_ready = (count < CNT_W'(DEPTH));
  assign push      = req_valid && req_ready;
  assign busy      = (count != '0) || (state_q != IDLE);

  // Storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= req_addr;
      data_mem[wr_ptr] <= req_data;
      rnw_mem[wr_ptr]  <= req_R_nW;
      tag_mem[wr_ptr]  <= req_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_R_nW  <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
    end else begin
      state_q   <= state_d;
      mem_req   <= mem_req_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_R_nW  <= mem_R_nW_d;
      res_valid <= res_valid_d;
      res_data  <= res_data_d;
      res_tag   <= res_tag_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_R_nW_d  = mem_R_nW;
    res_valid_d = res_valid;
    res_data_d  = res_data;
    res_tag_d   = res_tag;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (count != '0) begin
          mem_addr_d  = addr_mem[rd_ptr];
          mem_wdata_d = data_mem[rd_ptr];
          mem_R_nW_d  = rnw_mem[rd_ptr];
          mem_req_d   = 1'b1;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        // The head stays in the FIFO for the whole access so its tag is still at rd_ptr here.
        if (mem_ack && mem_req) begin
          pop       = 1'b1;
          mem_req_d = 1'b0;
          if (mem_R_nW) begin
            res_valid_d = 1'b1;
            res_data_d  = 16'(mem_rdata);
            res_tag_d   = tag_mem[rd_ptr];
            state_d     = RESP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/ls_mem_sequencer.md
Name: ls_mem_sequencer

Overview:
- Sits between the Execute stage LS outputs (25-bit address, 8-bit data, read/write flag, 5-bit Rd tag) and external byte-wide memory.
- Buffers LS requests in an in-order FIFO and issues them one at a time over a req/ack handshake.
- Returns load data with its Rd tag on a valid/ready result port for writeback.
- Stores complete silently.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
ADDR_W, 25, memory address width
DATA_W, 8, memory data width
TAG_W, 5, Rd tag width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  LS request present
req_ready  out  1  FIFO can accept
req_addr  in  ADDR_W  byte address
req_data  in  DATA_W  store data
req_R_nW  in  1  1 = load, 0 = store
req_tag  in  TAG_W  Rd tag
mem_req  out  1  memory access request
mem_addr  out  ADDR_W  access address
mem_wdata  out  DATA_W  store data
mem_R_nW  out  1  1 = read, 0 = write
mem_ack  in  1  access complete; mem_rdata valid this cycle for reads
mem_rdata  in  DATA_W  read data
res_valid  out  1  load result available
res_ready  in  1  writeback accepts result
res_data  out  16  load byte zero-extended to 16 bits
res_tag  out  TAG_W  Rd tag of load
busy  out  1  FIFO non-empty or FSM not IDLE
count  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:

Reset (async, rst_n low):
- FIFO emptied; count=0; FSM to IDLE.
- mem_req=0, mem_addr=0, mem_wdata=0, mem_R_nW=1 (default read).
- res_valid=0, res_data=0, res_tag=0, busy=0.
- req_ready reads 1 once reset is applied.
- Reset mid-access drops mem_req immediately. Any in-flight access is abandoned and no result is produced.

FIFO:
- req_ready = (count < DEPTH), combinational from count only. There is no pass-through when full.
- Push on req_valid && req_ready.
- Push and pop in the same cycle leaves count unchanged.
- Pointers wrap modulo DEPTH.
- Requests are issued strictly in push order.

FSM states:
- IDLE: if count != 0, register the head entry into mem_addr/mem_wdata/mem_R_nW, set mem_req=1, and go to ACCESS. The earliest mem_req is the cycle after the push (latency 1).
- ACCESS: mem_req and all mem_* outputs are held stable until the mem_ack edge. On mem_ack:
  - Pop the head and clear mem_req.
  - Store: go to IDLE.
  - Load: capture {8'b0, mem_rdata} into res_data and the head tag into res_tag, set res_valid=1, go to RESP.
  - mem_ack may arrive in the first ACCESS cycle (zero wait states).
- RESP: res_valid, res_data and res_tag are held until res_ready is sampled high. Then clear res_valid and go to IDLE.
  - res_ready high on the first RESP cycle gives a one-cycle pulse.
  - FIFO pushes continue during RESP.

Other rules:
- mem_ack while mem_req=0 is ignored.
- res_ready outside RESP is ignored.
- At most one memory access is outstanding at any time.
- busy = (count != 0) || (state != IDLE).

Throughput:
- Store: 2 cycles minimum (IDLE, ACCESS with immediate ack).
- Load: 3 cycles minimum (IDLE, ACCESS, RESP).

Test Plan:
- Reset then idle -> req_ready=1, mem_req=0, mem_R_nW=1, count=0, busy=0.
- Single load: addr 0x1ABCDEF, tag 7, mem_ack after 2 wait cycles with rdata 0xA5 -> mem_req high 1 cycle after push and held 3 cycles with addr stable; res_valid the next cycle with res_data=0x00A5, res_tag=7; cleared when res_ready=1.
- Store: addr 0x0000010, data 0x3C, immediate ack -> mem_R_nW=0, mem_wdata=0x3C for 1 cycle; no res_valid; busy falls 1 cycle later.
- Fill to DEPTH=4 with mem_ack held low -> req_ready=0 at count=4; a fifth req_valid is not accepted. After ack, count=3 and req_ready=1. All 4 requests issue in order with tags 1,2,3,4.
- Load result with res_ready low for 5 cycles while 2 more requests are pushed -> result held stable, no new mem_req until RESP exits, count=2.
- rst_n asserted mid-ACCESS -> mem_req falls without waiting for the clock; after release count=0 and no res_valid appears for the abandoned load.
